// File: rtl/lcmv_pkg.sv
// Shared types and defaults for the LCMV datapath schedulers.
// tag_t is sized from DEF_N_REQ; instantiate schedulers with N_REQ = DEF_N_REQ.
package lcmv_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_LATENCY = 11;
    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned TAG_W       = $clog2(DEF_N_REQ);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic v;
        tag_t tag;
    } tag_stage_t;

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// Requester-side bus of the shared adder scheduler: operands in, grant and result out.
interface fp_adder_arbiter_if
    import lcmv_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][WIDTH-1:0] req_a;
    logic [N_REQ-1:0][WIDTH-1:0] req_b;
    logic [N_REQ-1:0]            req_grant;
    logic [N_REQ-1:0]            resp_valid;
    logic [WIDTH-1:0]            resp_o;

    modport master (
        output req_valid, req_a, req_b,
        input  req_grant, resp_valid, resp_o
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_grant, resp_valid, resp_o
    );

endinterface

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
// Priority starts one past the last granted requester; requester 0 first after reset.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] idx_c
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] last;
    logic          found;
    int unsigned   k;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(last) + 32'd1 + i) % N;
            if (!found && req[IW'(k)]) begin
                found            = 1'b1;
                grant_c[IW'(k)]  = 1'b1;
                idx_c            = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(N - 1);
        end else if (found) begin
            last <= idx_c;
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one fixed-latency pipelined fp_adder among N_REQ requesters, tagging each
// issued op with its requester and steering the result back; flags tag/valid skew.
module fp_adder_arbiter
    import lcmv_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned N_REQ   = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             rst,
    fp_adder_arbiter_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ready,
    input  logic [WIDTH-1:0] add_o,
    input  logic             add_valid,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CW = $clog2(LATENCY + 2);

    logic [N_REQ-1:0] grant_c;
    tag_t             idx_c;
    logic             issue;
    tag_t             iss_tag;
    tag_stage_t       pipe [LATENCY];
    tag_stage_t       head;
    logic [CW-1:0]    cnt;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .grant_c (grant_c),
        .idx_c   (idx_c)
    );

    assign bus.req_grant = grant_c;
    assign issue         = |grant_c;
    assign head          = pipe[LATENCY-1];
    assign busy          = (cnt != '0);

    // Issue register; operands hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_ready <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            iss_tag   <= '0;
        end else begin
            add_ready <= issue;
            if (issue) begin
                add_a   <= bus.req_a[idx_c];
                add_b   <= bus.req_b[idx_c];
                iss_tag <= idx_c;
            end
        end
    end

    // Stage 0 captures the issue register, so the head lines up with add_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{v: add_ready, tag: iss_tag};
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // In-flight count from grant to head retirement, plus sticky skew flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            case ({issue, head.v})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (add_valid != head.v) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.resp_valid = '0;
        bus.resp_o     = add_o;
        if (add_valid && head.v) begin
            bus.resp_valid[head.tag] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench for fp_adder_arbiter with a fixed-latency stub adder.
module tb_fp_adder_arbiter;
    import lcmv_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;
    localparam int unsigned L = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_adder_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    logic [W-1:0] add_a, add_b, add_o;
    logic         add_ready, add_valid, busy, err;

    fp_adder_arbiter #(.WIDTH(W), .LATENCY(L), .N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ready (add_ready),
        .add_o     (add_o),
        .add_valid (add_valid),
        .busy      (busy),
        .err       (err)
    );

    // Stub adder: integer sum, except the one hand-computed float pair.
    function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3FA66666 && b == 32'hC16CCCCD) return 32'hC1580000;
        return a + b;
    endfunction

    logic         sv [L];
    logic [W-1:0] so [L];
    logic         spur = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(L); i++) begin
                sv[i] <= 1'b0;
                so[i] <= '0;
            end
        end else begin
            sv[0] <= add_ready;
            so[0] <= fadd(add_a, add_b);
            for (int i = 1; i < int'(L); i++) begin
                sv[i] <= sv[i-1];
                so[i] <= so[i-1];
            end
        end
    end

    assign add_valid = sv[L-1] | spur;
    assign add_o     = so[L-1];

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int           idx;
        logic [W-1:0] val;
        int           due;
    } exp_t;

    exp_t q[$];
    int   gq[$];
    int   mlast = N - 1;
    bit   miss  = 1'b0;
    int   mcnt  = 0;
    bit   merr  = 1'b0;
    int   wt [N];

    function automatic int rr_pick(input logic [N-1:0] rv, input int last);
        for (int i = 1; i <= int'(N); i++) begin
            int k;
            k = (last + i) % int'(N);
            if (rv[k]) return k;
        end
        return -1;
    endfunction

    // Monitor: grant model, issue strobe, response scoreboard, busy/err model, fairness.
    always @(negedge clk) begin : mon
        int           p;
        logic [N-1:0] eg;
        bit           rsp;
        exp_t         e;
        if (cyc >= 1) begin
            p  = rr_pick(bus.req_valid, mlast);
            eg = (p >= 0) ? (N'(1) << p) : '0;
            check("grant", 32'(bus.req_grant), 32'(eg));
            check("add_ready", 32'(add_ready), 32'(miss));

            rsp = 1'b0;
            if (bus.resp_valid != '0) begin
                rsp = 1'b1;
                if (q.size() == 0) begin
                    check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("resp_valid", 32'(bus.resp_valid), 32'd1 << e.idx);
                    check("resp_o", 32'(bus.resp_o), 32'(e.val));
                    check("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("resp_missing", 32'(bus.resp_valid), 32'd1 << e.idx);
            end

            check("busy", 32'(busy), 32'(mcnt != 0));
            check("err", 32'(err), 32'(merr));

            for (int i = 0; i < int'(N); i++) begin
                if (bus.req_valid[i] && !bus.req_grant[i]) begin
                    wt[i]++;
                    check("wait_bound", 32'(wt[i] > int'(N) - 1), 32'd0);
                end else begin
                    wt[i] = 0;
                end
            end

            if (rst) begin
                mlast = N - 1;
                miss  = 1'b0;
                mcnt  = 0;
                merr  = 1'b0;
                q.delete();
            end else begin
                if (p >= 0) begin
                    q.push_back('{idx: p, val: fadd(bus.req_a[p], bus.req_b[p]), due: cyc + int'(L) + 1});
                    gq.push_back(p);
                    mlast = p;
                    mcnt++;
                end
                miss = (p >= 0);
                if (rsp) mcnt--;
                if (spur) merr = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) wt[i] = 0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_grant", 32'(bus.req_grant), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_o", 32'(bus.resp_o), 32'(add_o));
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_add_ready", 32'(add_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);

        // Single request from requester 2: 1.3 + -14.8
        bus.req_a[2]  = 32'h3FA66666;
        bus.req_b[2]  = 32'hC16CCCCD;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("t1_grant", 32'(bus.req_grant), 32'h4);
        step(1);
        bus.req_valid = '0;
        repeat (L) @(posedge clk);
        @(negedge clk);
        check("t1_resp_valid", 32'(bus.resp_valid), 32'h4);
        check("t1_resp_o", 32'(bus.resp_o), 32'hC1580000);
        check("t1_busy_at_resp", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);
        step(2);

        // Three issues, then reset before any returns
        for (int i = 0; i < int'(N); i++) begin
            bus.req_a[i] = 32'h100 * (i + 1);
            bus.req_b[i] = 32'h7 + i;
        end
        bus.req_valid = 4'b0111;
        step(3);
        bus.req_valid = '0;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("t4_busy_post_rst", 32'(busy), 32'd0);
        check("t4_err_post_rst", 32'(err), 32'd0);
        step(1);
        bus.req_valid = 4'b1000;
        step(1);
        bus.req_valid = '0;
        step(int'(L) + 4);

        // All four held valid for 8 cycles
        for (int i = 0; i < int'(N); i++) begin
            bus.req_a[i] = 32'h1000 + 32'h11 * i;
            bus.req_b[i] = 32'h20 * (i + 3);
        end
        gq.delete();
        bus.req_valid = 4'b1111;
        step(8);
        bus.req_valid = '0;
        step(int'(L) + 4);
        check("t2_grant_count", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gq.size(); i++) begin
            check("t2_grant_order", 32'(gq[i]), 32'(i % 4));
        end

        // 1 and 3 held, 0 and 2 toggle
        for (int i = 0; i < int'(N); i++) begin
            bus.req_a[i] = 32'hABC0 + i;
            bus.req_b[i] = 32'h5 * (i + 1);
        end
        for (int c = 0; c < 16; c++) begin
            bus.req_valid = {1'b1, c[0], 1'b1, c[0]};
            step(1);
        end
        bus.req_valid = '0;
        step(int'(L) + 4);
        @(negedge clk);
        check("t3_busy_idle", 32'(busy), 32'd0);
        step(1);

        // Spurious add_valid with nothing in flight
        spur = 1'b1;
        @(negedge clk);
        check("t5_err_same_cycle", 32'(err), 32'd0);
        check("t5_no_resp", 32'(bus.resp_valid), 32'd0);
        step(1);
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_err_sticky", 32'(err), 32'd1);
            check("t5_no_resp_after", 32'(bus.resp_valid), 32'd0);
            step(1);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", 32'(err), 32'd0);
        step(2);

        check("drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin scheduler sharing one pipelined `fp_adder` (fixed LATENCY, no backpressure) among N_REQ requesters in the LCMV datapath. It issues at most one addition per cycle, tags each in-flight operation with its requester index in a shift register aligned to the adder pipeline, and steers each result back to the requester that issued it. It also flags any misalignment between the tag pipeline and the adder's `valid` strobe.

## Interface
- WIDTH, 32, operand/result width (IEEE-754 single at 32)
- LATENCY, 11, adder cycles from `add_ready` high to `add_valid` high
- N_REQ, 4, number of requesters (≥2)

- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset; also drives the adder's `rst`
- req_valid  in  N_REQ  requester i has an operation pending
- req_a, req_b  in  N_REQ×WIDTH  operands per requester
- req_grant  out  N_REQ  one-hot or zero; operation i consumed at this edge
- resp_valid  out  N_REQ  one-hot or zero; result for requester i this cycle
- resp_o  out  WIDTH  shared result bus, meaningful only with a resp_valid bit set
- add_a, add_b  out  WIDTH  to adder `a`, `b`
- add_ready  out  1  to adder `ready` (input strobe)
- add_o  in  WIDTH  from adder `o`
- add_valid  in  1  from adder `valid`
- busy  out  1  at least one operation in flight
- err  out  1  sticky misalignment flag

## Operation
- Arbitration is combinational and round-robin. Priority starts at `(last_grant+1) mod N_REQ`.
  - `last_grant` resets to N_REQ-1, so requester 0 has top priority after reset.
  - `last_grant` updates only on a grant.
- At most one `req_grant` bit per cycle. A grant is given whenever any `req_valid` is high.
- Requesters hold `req_a`/`req_b` stable while `req_valid` is high. A request is consumed on the edge where its grant is high.
- Issue register, updated every cycle:
  - `add_ready` ← any grant.
  - `add_a`/`add_b` ← granted operands.
  - Operands hold their old value when there is no grant.
- Tag pipeline: LATENCY stages of {v, tag[$clog2(N_REQ)-1:0]}.
  - Stage 0 loads {add_ready, issued tag} in the same edge that updates `add_ready`.
  - The pipeline shifts every cycle and all stages are cleared on rst.
  - The head (stage LATENCY-1) aligns with `add_valid`.
- Response steering (combinational from the head):
  - `resp_valid[head.tag]` = `add_valid & head.v`.
  - `resp_o` = `add_o`.
- Requesters have no backpressure and must accept a response on the cycle it appears.
- In-flight counter, width `$clog2(LATENCY+2)`:
  - +1 on issue, -1 on `head.v`.
  - Simultaneous issue and retire leaves it unchanged.
  - Maximum value is LATENCY+1 (wrap is impossible).
  - `busy` = count≠0.
- `err` is set when `add_valid != head.v` in any cycle. It stays set until rst. Steering still follows `head.v` after `err` is set.
- Reset mid-operation:
  - Tag pipeline, counter and issue register are cleared.
  - All in-flight results are discarded.
  - No `resp_valid` is raised for them.
  - `err` does not fire, because the adder is reset on the same edge.

## Timing
- Reset values: `req_grant`=0, `resp_valid`=0, `resp_o`=`add_o` (pass-through), `add_a`=`add_b`=0, `add_ready`=0, `busy`=0, `err`=0, `last_grant`=N_REQ-1.
- `req_grant` depends combinationally on `req_valid` and `last_grant`; there is no combinational path from `req_a`/`req_b`.
- Grant at edge t → `add_ready` high during cycle t+1 → `resp_valid` high during cycle t+1+LATENCY.
- End-to-end latency is LATENCY+1 cycles.
- Throughput is 1 op/cycle. Back-to-back grants produce back-to-back responses, in issue order.

## Structure
- Shared package `lcmv_pkg` holds:
  - default `WIDTH` and `LATENCY`;
  - `tag_t` typedef, sized `$clog2(N_REQ)`;
  - `tag_stage_t` struct {v, tag}.
- One sub-module, `rr_arbiter` (parameter N, combinational grant plus registered pointer), reusable by later shared-resource schedulers (multiplier, divider).
- The adder is instantiated by the parent, not inside this block.

## Test plan
- Single request: req 2 with a=1.3, b=-14.8 → `req_grant`=4'b0100 for one cycle; `resp_valid`=4'b0100 exactly 12 cycles later with `resp_o`≈-13.5; `busy` high throughout, low afterwards.
- All four requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order on 8 consecutive cycles, each carrying its own sum.
- Requesters 1 and 3 held valid while 0 and 2 toggle → no requester waits more than N_REQ-1 cycles; the counter never exceeds 12; `busy` falls one cycle after the last response.
- rst asserted 5 cycles after 3 issues → no `resp_valid` for them; `busy`=0 and `err`=0 on the cycle after reset; a new request then completes normally in 12 cycles.
- Stub adder drives a spurious `add_valid` with no op in flight → `err` rises the next cycle and stays high until rst; no `resp_valid` bit is raised.
